regfile_mp: RTL



---
 rtl/regfile_mp_pkg.sv | 23 ++
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/regfile_mp.sv | 103 ++++++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default widths,
// the zero word, the control-signal encodings and a packed-vector slice helper.
`ifndef REGFILE_MP_PKG_SV
`define REGFILE_MP_PKG_SV

// Port i of a packed multi-port vector whose ports are w bits wide.
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package regfile_mp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

  // Control encodings carried over from the single-write/dual-read regfile.
  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

endpackage

`endif

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard. Issue ports set busy, writeback ports clear it;
// a set in the same cycle as a clear wins because the new producer supersedes
// the retiring one. busy_nxt is the post-edge busy state, exported so the read
// ports can report it with the same one-cycle latency as the data.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 2,
  parameter int NUM_ISS  = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_ISS-1:0]        iss_en,
  input  logic [NUM_ISS*ADDR_W-1:0] iss_addr,
  input  logic [NUM_WR-1:0]         wb_clr,
  input  logic [NUM_WR*ADDR_W-1:0]  waddr,
  output logic [(2**ADDR_W)-1:0]    busy_nxt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;

  // Decode issue/clear ports into per-register masks and apply set-over-clear.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int n = 0; n < NUM_ISS; n++) begin
      if (iss_en[n]) set_vec[`RF_SLICE(iss_addr, n, ADDR_W)] = 1'b1;
    end
    for (int i = 0; i < NUM_WR; i++) begin
      if (wb_clr[i]) clr_vec[`RF_SLICE(waddr, i, ADDR_W)] = 1'b1;
    end
    busy_nxt = set_vec | (busy & ~clr_vec);
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  // Busy-bit state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file for the dual-issue pipeline: NUM_WR write ports
// (highest index wins on address collision), NUM_RD registered read ports with
// write-to-read bypass, and a busy scoreboard reported alongside read data.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int NUM_ISS  = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_WR-1:0]         we,
  input  logic [NUM_WR*ADDR_W-1:0]  waddr,
  input  logic [NUM_WR*DATA_W-1:0]  wdata,
  input  logic [NUM_RD-1:0]         re,
  input  logic [NUM_RD*ADDR_W-1:0]  raddr,
  output logic [NUM_RD*DATA_W-1:0]  rdata,
  output logic [NUM_RD-1:0]         rbusy,
  input  logic [NUM_ISS-1:0]        iss_en,
  input  logic [NUM_ISS*ADDR_W-1:0] iss_addr,
  input  logic [NUM_WR-1:0]         wb_clr
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]         busy_nxt;
  logic [NUM_WR-1:0]        wr_ok;
  logic [DATA_W-1:0]        rd_nxt [NUM_RD];
  logic [NUM_RD-1:0]        rbusy_nxt;
  logic [NUM_RD*DATA_W-1:0] rdata_p1;
  logic [NUM_RD-1:0]        rbusy_p1;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .NUM_ISS  (NUM_ISS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wb_clr   (wb_clr),
    .waddr    (waddr),
    .busy_nxt (busy_nxt)
  );

  // A write port is effective unless it targets the hardwired zero register.
  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      wr_ok[i] = (we[i] == WRITE_ENABLE) &&
                 !((ZERO_REG != 0) && (`RF_SLICE(waddr, i, ADDR_W) == '0));
    end
  end

  // Read-port selection: disable/zero-reg, then bypass from the highest matching writer, else storage.
  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      rd_nxt[j]    = regs[`RF_SLICE(raddr, j, ADDR_W)];
      rbusy_nxt[j] = busy_nxt[`RF_SLICE(raddr, j, ADDR_W)];
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_ok[i] && (`RF_SLICE(waddr, i, ADDR_W) == `RF_SLICE(raddr, j, ADDR_W)))
          rd_nxt[j] = `RF_SLICE(wdata, i, DATA_W);
      end
      if ((re[j] != READ_ENABLE) ||
          ((ZERO_REG != 0) && (`RF_SLICE(raddr, j, ADDR_W) == '0))) begin
        rd_nxt[j]    = '0;
        rbusy_nxt[j] = 1'b0;
      end
    end
  end

  // Storage update; later ports are assigned last so the highest index wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_ok[i]) regs[`RF_SLICE(waddr, i, ADDR_W)] <= `RF_SLICE(wdata, i, DATA_W);
      end
    end
  end

  // Stage p1: registered read data and busy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_p1 <= '0;
      rbusy_p1 <= '0;
    end else begin
      for (int j = 0; j < NUM_RD; j++) rdata_p1[j*DATA_W +: DATA_W] <= rd_nxt[j];
      rbusy_p1 <= rbusy_nxt;
    end
  end

  assign rdata = rdata_p1;
  assign rbusy = rbusy_p1;

endmodule
